// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl: boot/run/dump harness for the single-cycle MIPS32 core.
//
// Loads the core's instruction and data memories from a streaming load
// port. It then releases the core and counts executed cycles until a halt
// opcode is seen or the cycle budget runs out. After that it streams the
// whole register file out over a ready/valid dump port.
//
// Ports
//   clk_x, rst             single clock, synchronous active-high reset
//   ld_valid/ld_ready      load beat handshake
//   ld_sel                 0 = IMEM, 1 = DMEM
//   ld_addr/ld_data        load address / word
//   ld_last                final load beat; the run starts after it
//   run_budget             cycle budget, latched on the last beat (0 = unlimited)
//   imem_we/dmem_we        memory write strobes (same cycle as beat acceptance)
//   mem_addr/mem_wdata     shared write address / data (passthrough of load port)
//   core_rst/core_run      core reset / core enable
//   core_instr             instruction the core executes this cycle
//   rf_raddr/rf_rdata      register-file debug read port
//   dump_valid/dump_ready  dump beat handshake
//   dump_idx/dump_data     register index / value of the current beat
//   restart                DONE -> LOAD
//   done                   dump finished
//   timeout                run ended by budget rather than halt
//   cycle_cnt              RUN cycles executed
//
// State | meaning
// ------+---------------------------------------------------------------
// LOAD  | core held in reset, load beats written into IMEM/DMEM
// RUN   | core enabled, cycles counted, waiting for halt or budget expiry
// DUMP  | core frozen, register file streamed out one index per handshake
// DONE  | dump complete, results held until restart

module mips_boot_ctrl #(
  parameter int         DATA_W  = 32,
  parameter int         LD_AW   = 10,
  parameter int         REG_AW  = 5,
  parameter int         CNT_W   = 16,
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic              clk_x,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [LD_AW-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [CNT_W-1:0]  run_budget,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [LD_AW-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              core_run,
  input  logic [DATA_W-1:0] core_instr,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  input  logic              restart,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cycle_q;
  logic [CNT_W-1:0]    budget_left_q;
  logic                timeout_q;
  logic [REG_AW-1:0]   idx_q;

  logic                ld_fire;
  logic                last_fire;
  logic                in_run;
  logic                halt_hit;
  logic                budget_hit;
  logic                dump_fire;
  logic                last_idx;
  logic                unused_instr_bits;

  // Handshake qualifiers are derived from the state register directly so the
  // FSM block never consumes its own combinational outputs.
  assign ld_fire    = ld_valid & (state_q == ST_LOAD);
  assign last_fire  = ld_fire & ld_last;
  assign in_run     = (state_q == ST_RUN);
  assign dump_fire  = dump_ready & (state_q == ST_DUMP);
  assign last_idx   = (idx_q == {REG_AW{1'b1}});

  assign halt_hit   = (core_instr[DATA_W-1 -: 6] == HALT_OP);

  // Budget is tracked as a down-counter loaded on the last load beat. A value
  // of one means this RUN cycle is the last one the budget allows; zero means
  // unlimited and is never decremented.
  assign budget_hit = (budget_left_q == CNT_W'(1));

  assign unused_instr_bits = ^core_instr[DATA_W-7:0];

  // Write path has zero latency: strobes, address and data follow the load
  // port combinationally.
  assign imem_we   = ld_fire & ~ld_sel;
  assign dmem_we   = ld_fire &  ld_sel;
  assign mem_addr  = ld_addr;
  assign mem_wdata = ld_data;

  assign rf_raddr  = idx_q;
  assign dump_idx  = idx_q;
  assign dump_data = rf_rdata;
  assign cycle_cnt = cycle_q;
  assign timeout   = timeout_q;

  always_ff @(posedge clk_x) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_ready   = 1'b0;
    core_rst   = 1'b0;
    core_run   = 1'b0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        core_rst = 1'b1;
        if (last_fire) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (halt_hit || budget_hit) begin
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        if (dump_ready && last_idx) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (restart) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Cycle counter, budget down-counter and timeout flag.
  always_ff @(posedge clk_x) begin
    if (rst) begin
      cycle_q       <= '0;
      budget_left_q <= '0;
      timeout_q     <= 1'b0;
    end else if (last_fire) begin
      cycle_q       <= '0;
      budget_left_q <= run_budget;
      timeout_q     <= 1'b0;
    end else if (in_run) begin
      // Saturates so an unlimited run never wraps back to small counts.
      if (cycle_q != {CNT_W{1'b1}}) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      // Halt wins over budget expiry in the same cycle.
      if (halt_hit) begin
        timeout_q <= 1'b0;
      end else if (budget_hit) begin
        timeout_q <= 1'b1;
      end
      if (budget_left_q > CNT_W'(1)) begin
        budget_left_q <= budget_left_q - CNT_W'(1);
      end
    end
  end

  // Dump index; wraps to zero after the final register so the next dump
  // starts from index 0 without an explicit clear.
  always_ff @(posedge clk_x) begin
    if (rst) begin
      idx_q <= '0;
    end else if (dump_fire) begin
      idx_q <= idx_q + REG_AW'(1);
    end
  end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
module tb_mips_boot_ctrl;
  localparam int DATA_W = 32;
  localparam int LD_AW  = 10;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;
  localparam int NREG   = 1 << REG_AW;

  logic              clk_x = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_sel;
  logic [LD_AW-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [CNT_W-1:0]  run_budget;
  logic              imem_we;
  logic              dmem_we;
  logic [LD_AW-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_rst;
  logic              core_run;
  logic [DATA_W-1:0] core_instr;
  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [REG_AW-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              restart;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_cnt;

  always #5 clk_x = ~clk_x;

  mips_boot_ctrl #(
    .DATA_W(DATA_W), .LD_AW(LD_AW), .REG_AW(REG_AW), .CNT_W(CNT_W), .HALT_OP(6'h3F)
  ) dut (
    .clk_x(clk_x), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .run_budget(run_budget),
    .imem_we(imem_we), .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .core_run(core_run), .core_instr(core_instr),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data),
    .restart(restart), .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  typedef struct packed {
    logic              sel;
    logic [LD_AW-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [REG_AW-1:0] idx;
    logic [DATA_W-1:0] data;
  } dump_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             to;
  } run_t;

  wr_t   exp_wr[$];
  dump_t exp_dump[$];
  run_t  exp_run[$];

  int total = 0;
  int bad   = 0;
  int run_cyc = 0;
  int halt_at = 0;
  int imem_n = 0;
  int dmem_n = 0;
  bit noise_en = 1'b0;
  bit rdy_rand = 1'b0;
  logic [DATA_W-1:0] rf_mem [NREG];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=unexpected want=none (t=%0t)", nm, $time);
  endtask

  // Core model: counts its own executed cycles and issues the halt opcode on
  // the chosen cycle; otherwise near-miss opcodes.
  always @(posedge clk_x) begin
    if (core_rst) run_cyc <= 0;
    else if (core_run) run_cyc <= run_cyc + 1;
  end

  always_comb begin
    if (halt_at != 0 && run_cyc == halt_at - 1)
      core_instr = 32'hFFFF_0005;
    else
      core_instr = {(run_cyc[0] ? 6'h3E : 6'h1F), 26'(run_cyc)};
  end

  always_comb rf_rdata = rf_mem[rf_raddr];

  // Monitor / scoreboard
  wr_t   mw;
  dump_t md;
  run_t  mr;
  logic              prev_dv    = 1'b0;
  logic              prev_stall = 1'b0;
  logic [REG_AW-1:0] prev_idx;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk_x) begin
    if (imem_we === 1'b1 || dmem_we === 1'b1) begin
      if (imem_we === 1'b1) imem_n++;
      if (dmem_we === 1'b1) dmem_n++;
      if (exp_wr.size() == 0) begin
        fail_now("wr_unexpected");
      end else begin
        mw = exp_wr.pop_front();
        chk("wr_strobes", {62'd0, imem_we, dmem_we}, mw.sel ? 64'd1 : 64'd2);
        chk("wr_addr", 64'(mem_addr), 64'(mw.addr));
        chk("wr_data", 64'(mem_wdata), 64'(mw.data));
      end
    end
    if (dump_valid === 1'b1 && prev_dv !== 1'b1) begin
      if (exp_run.size() == 0) begin
        fail_now("dump_unexpected");
      end else begin
        mr = exp_run.pop_front();
        chk("run_cycle_cnt", 64'(cycle_cnt), 64'(mr.cnt));
        chk("run_timeout", 64'(timeout), 64'(mr.to));
        chk("run_core_off", 64'(core_run), 64'd0);
      end
    end
    if (prev_stall) begin
      chk("stall_valid", 64'(dump_valid), 64'd1);
      chk("stall_idx", 64'(dump_idx), 64'(prev_idx));
      chk("stall_data", 64'(dump_data), 64'(prev_data));
    end
    if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
      if (exp_dump.size() == 0) begin
        fail_now("beat_unexpected");
      end else begin
        md = exp_dump.pop_front();
        chk("beat_idx", 64'(dump_idx), 64'(md.idx));
        chk("beat_data", 64'(dump_data), 64'(md.data));
      end
    end
    prev_dv    = dump_valid;
    prev_stall = (dump_valid === 1'b1) && (dump_ready !== 1'b1);
    prev_idx   = dump_idx;
    prev_data  = dump_data;
  end

  // Sink readiness
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk_x);
      #1;
      dump_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Load-port and restart noise outside LOAD; must be ignored by the DUT.
  initial begin
    forever begin
      @(posedge clk_x);
      #2;
      if (noise_en) begin
        ld_valid   = 1'($urandom);
        ld_sel     = 1'($urandom);
        ld_addr    = LD_AW'($urandom);
        ld_data    = $urandom;
        ld_last    = 1'($urandom);
        run_budget = CNT_W'($urandom);
        restart    = done ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=hang want=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_rand();
    ld_valid   = 1'b0;
    ld_sel     = 1'($urandom);
    ld_addr    = LD_AW'($urandom);
    ld_data    = $urandom;
    ld_last    = 1'($urandom);
    run_budget = CNT_W'($urandom);
  endtask

  task automatic send_beat(input logic sel, input logic [LD_AW-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic last,
                           input logic [CNT_W-1:0] budget);
    wr_t w;
    ld_valid   = 1'b1;
    ld_sel     = sel;
    ld_addr    = addr;
    ld_data    = data;
    ld_last    = last;
    run_budget = last ? budget : CNT_W'($urandom);
    w.sel = sel; w.addr = addr; w.data = data;
    exp_wr.push_back(w);
    @(posedge clk_x);
    #1;
    idle_rand();
    if (!last) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_x);
        #1;
        idle_rand();
      end
    end
  endtask

  task automatic do_test(input int budget, input int hlt, input int nbeats,
                         input bit spec_load, input bit pat_rf, input bit rnd_rdy);
    run_t  r;
    dump_t d;
    int    n_dv;
    bit    got;
    int    i0;
    int    d0;
    int    addrs[10];
    bit    sels[10];
    addrs = '{1, 2, 0, 3, 4, 0, 5, 6, 0, 13};
    sels  = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};

    for (int i = 0; i < NREG; i++) begin
      rf_mem[i] = pat_rf ? DATA_W'(i * 32'h1111) : $urandom;
      d.idx = REG_AW'(i);
      d.data = rf_mem[i];
      exp_dump.push_back(d);
    end
    // Run ends at the halt cycle unless the budget runs out strictly earlier.
    if (hlt != 0 && (budget == 0 || hlt <= budget)) begin
      r.cnt = CNT_W'(hlt); r.to = 1'b0;
    end else begin
      r.cnt = CNT_W'(budget); r.to = 1'b1;
    end
    exp_run.push_back(r);
    halt_at = hlt;

    i0 = imem_n;
    d0 = dmem_n;
    if (spec_load) begin
      for (int i = 0; i < 10; i++)
        send_beat(sels[i], sels[i] ? LD_AW'($urandom) : LD_AW'(addrs[i]), $urandom,
                  i == 9, CNT_W'(budget));
      chk("imem_pulses", 64'(imem_n - i0), 64'd7);
      chk("dmem_pulses", 64'(dmem_n - d0), 64'd3);
    end else begin
      for (int i = 0; i < nbeats; i++)
        send_beat(1'($urandom), LD_AW'($urandom), $urandom, i == nbeats - 1, CNT_W'(budget));
    end
    chk("run_start", 64'(core_run), 64'd1);
    chk("ld_ready_run", 64'(ld_ready), 64'd0);
    chk("wrq_empty", 64'(exp_wr.size()), 64'd0);

    noise_en = 1'b1;
    rdy_rand = rnd_rdy;

    if (hlt >= 1000) begin
      for (int c = 0; c < 1200 && run_cyc != 1000; c++) begin
        @(posedge clk_x);
        #1;
      end
      chk("nobudget_cnt", 64'(cycle_cnt), 64'd1000);
      chk("nobudget_timeout", 64'(timeout), 64'd0);
      chk("nobudget_running", 64'(core_run), 64'd1);
    end

    n_dv = 0;
    got  = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk_x);
      #1;
      if (dump_valid) n_dv++;
      if (done) got = 1'b1;
    end
    noise_en = 1'b0;
    rdy_rand = 1'b0;
    ld_valid = 1'b0;
    restart  = 1'b0;
    chk("done_seen", 64'(got), 64'd1);

    if (got) begin
      if (!rnd_rdy) chk("dump_len", 64'(n_dv), 64'd32);
      repeat (3) begin
        @(posedge clk_x);
        #1;
      end
      chk("done_hold", 64'(done), 64'd1);
      chk("cnt_hold", 64'(cycle_cnt), 64'(r.cnt));
      chk("timeout_hold", 64'(timeout), 64'(r.to));
      chk("core_frozen", 64'(core_run), 64'd0);
      chk("dumpq_empty", 64'(exp_dump.size()), 64'd0);
      chk("runq_empty", 64'(exp_run.size()), 64'd0);
      restart = 1'b1;
      @(posedge clk_x);
      #1;
      restart = 1'b0;
      chk("restart_done", 64'(done), 64'd0);
      chk("restart_ld_ready", 64'(ld_ready), 64'd1);
      chk("restart_core_rst", 64'(core_rst), 64'd1);
    end else begin
      rst = 1'b1;
      @(posedge clk_x);
      #1;
      rst = 1'b0;
      exp_dump.delete();
      exp_run.delete();
    end
  endtask

  task automatic reset_mid_run();
    halt_at = 0;
    send_beat(1'b0, LD_AW'(7), $urandom, 1'b0, CNT_W'(100));
    send_beat(1'b1, LD_AW'(9), $urandom, 1'b1, CNT_W'(100));
    for (int c = 0; c < 20 && run_cyc != 2; c++) begin
      @(posedge clk_x);
      #1;
    end
    chk("rmr_cnt_before", 64'(cycle_cnt), 64'd2);
    rst = 1'b1;
    @(posedge clk_x);
    #1;
    rst = 1'b0;
    chk("rmr_core_rst", 64'(core_rst), 64'd1);
    chk("rmr_ld_ready", 64'(ld_ready), 64'd1);
    chk("rmr_core_run", 64'(core_run), 64'd0);
    chk("rmr_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("rmr_timeout", 64'(timeout), 64'd0);
    repeat (40) begin
      @(posedge clk_x);
      #1;
    end
    chk("rmr_no_dump", 64'(dump_valid), 64'd0);
    chk("rmr_still_load", 64'(ld_ready), 64'd1);
  endtask

  initial begin
    rst        = 1'b1;
    restart    = 1'b0;
    ld_valid   = 1'b0;
    ld_sel     = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    ld_last    = 1'b0;
    run_budget = '0;
    for (int i = 0; i < NREG; i++) rf_mem[i] = '0;

    repeat (2) @(posedge clk_x);
    #1;
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_core_run", 64'(core_run), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_dump_idx", 64'(dump_idx), 64'd0);
    chk("rst_rf_raddr", 64'(rf_raddr), 64'd0);
    chk("rst_strobes", {62'd0, imem_we, dmem_we}, 64'd0);
    rst = 1'b0;

    do_test(100, 7, 0, 1'b1, 1'b0, 1'b0);
    do_test(5, 0, 3, 1'b0, 1'b0, 1'b0);
    do_test(5, 5, 2, 1'b0, 1'b0, 1'b0);
    do_test(5, 6, 2, 1'b0, 1'b0, 1'b1);
    do_test(1, 0, 1, 1'b0, 1'b0, 1'b0);
    do_test(1, 1, 1, 1'b0, 1'b0, 1'b0);
    do_test(0, 1010, 2, 1'b0, 1'b0, 1'b0);
    do_test(3, 0, 4, 1'b0, 1'b1, 1'b1);
    reset_mid_run();
    do_test(20, 9, 3, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      int b;
      int h;
      b = $urandom_range(0, 40);
      h = $urandom_range(0, 45);
      if (b == 0 && h == 0) h = 20;
      do_test(b, h, $urandom_range(1, 6), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_boot_ctrl.md
# mips_boot_ctrl

Boot, run and dump controller for the single-cycle MIPS32 core. It loads the core's instruction and data memories from a streaming load port, then releases the core and counts executed cycles. The run ends on a halt opcode or when a cycle budget expires. The controller then streams the whole register file out over a ready/valid dump port. It sits beside `mips32` and replaces hierarchical memory preloading and register peeking with a reusable, parametrised hardware harness.

## Interface
Parameters:
- `DATA_W`, 32, memory/register word width
- `LD_AW`, 10, load address width (covers IMEM and DMEM depth)
- `REG_AW`, 5, register index width (2^REG_AW registers dumped)
- `CNT_W`, 16, cycle counter/budget width
- `HALT_OP`, 6'h3F, opcode (`instr[31:26]`) that ends a run

Ports (clock and reset first):
- `clk_x`, in, 1: single clock
- `rst`, in, 1: synchronous, active-high reset
- `ld_valid`, in, 1: load beat valid
- `ld_ready`, out, 1: controller accepts a load beat
- `ld_sel`, in, 1: load target, 0 = IMEM, 1 = DMEM
- `ld_addr`, in, LD_AW: word address
- `ld_data`, in, DATA_W: word to write
- `ld_last`, in, 1: final load beat; the run starts after it
- `run_budget`, in, CNT_W: cycle budget, latched on the last load beat; 0 = unlimited
- `imem_we`, out, 1: instruction-memory write strobe
- `dmem_we`, out, 1: data-memory write strobe
- `mem_addr`, out, LD_AW: shared write address (= `ld_addr`)
- `mem_wdata`, out, DATA_W: shared write data (= `ld_data`)
- `core_rst`, out, 1: core reset, high in LOAD
- `core_run`, out, 1: core enable; the core must freeze PC and all writes when low
- `core_instr`, in, DATA_W: instruction the core is executing this cycle
- `rf_raddr`, out, REG_AW: register-file debug read index
- `rf_rdata`, in, DATA_W: combinational register-file read data
- `dump_valid`, out, 1: dump beat valid
- `dump_ready`, in, 1: dump sink ready
- `dump_idx`, out, REG_AW: register index of the current beat
- `dump_data`, out, DATA_W: register value (= `rf_rdata`)
- `restart`, in, 1: return from DONE to LOAD
- `done`, out, 1: dump finished
- `timeout`, out, 1: run ended by budget, not by halt
- `cycle_cnt`, out, CNT_W: RUN cycles executed

## Operation
- States: LOAD, RUN, DUMP, DONE. `rst` forces LOAD.
- **LOAD**
  - `ld_ready`=1, `core_rst`=1, `core_run`=0.
  - A beat is accepted when `ld_valid & ld_ready`.
  - On acceptance, `imem_we` = `~ld_sel` and `dmem_we` = `ld_sel`, combinationally in the same cycle. The write path has zero latency.
  - An accepted beat with `ld_last`=1 latches `run_budget`, clears `cycle_cnt` and `timeout`, and goes to RUN.
  - Beats with `ld_valid`=0 are ignored. Duplicate addresses are allowed; the last write wins.
- **RUN**
  - `core_rst`=0, `core_run`=1, `ld_ready`=0.
  - `cycle_cnt` increments every RUN cycle, including the final one.
  - If `core_instr[31:26]==HALT_OP`, go to DUMP with `timeout`=0.
  - Else if the budget is non-zero and `cycle_cnt+1 == budget`, go to DUMP with `timeout`=1.
  - Halt takes priority when both occur in the same cycle.
  - With budget 0, `cycle_cnt` saturates at all-ones and the run never times out.
- **DUMP**
  - `core_run`=0 and `core_rst`=0; the register file must be preserved.
  - The index counter starts at 0. `rf_raddr` = `dump_idx` = index, `dump_valid`=1, `dump_data`=`rf_rdata`.
  - On `dump_valid & dump_ready` the index increments.
  - The beat at index 2^REG_AW−1 going out moves the state to DONE; the index wraps to 0.
- **DONE**
  - `done`=1, `core_run`=0. `cycle_cnt` and `timeout` hold.
  - `restart`=1 goes to LOAD and clears `done`. `restart` is ignored in all other states.

## Timing
- Reset values:
  - State LOAD.
  - `ld_ready`=1, `core_rst`=1.
  - All other outputs 0: `core_run`, `imem_we`, `dmem_we`, `dump_valid`, `dump_idx`, `rf_raddr`, `done`, `timeout`, `cycle_cnt`.
- `mem_addr` and `mem_wdata` are pure passthroughs of `ld_addr` and `ld_data`.
- `rst` mid-RUN or mid-DUMP: LOAD next cycle. The in-flight dump beat is dropped and counters clear.
- Latencies:
  - Last load beat to first RUN cycle: 1 clock.
  - Halt or timeout cycle to first `dump_valid`: 1 clock.
- The dump obeys ready/valid: `dump_idx` and `dump_data` are stable while `dump_valid & ~dump_ready`.
- A full dump takes 2^REG_AW clocks when `dump_ready` is held high.

## Test plan
- Reset check:
  - Stimulus: assert `rst` 2 cycles.
  - Response: `ld_ready`=1, `core_rst`=1, `core_run`=0, `done`=0, `cycle_cnt`=0.
- Load:
  - Stimulus: 7 IMEM beats (addrs 1–6, 13) and 3 DMEM beats; `ld_last` on the 10th; `ld_valid` gapped.
  - Response: exactly 7 `imem_we` and 3 `dmem_we` pulses with matching `mem_addr`/`mem_wdata`; `core_run`=1 the cycle after the 10th beat.
- Halt:
  - Stimulus: budget 100; `core_instr`=32'hFFFF_0005 on the 7th RUN cycle.
  - Response: `cycle_cnt`=7, `timeout`=0, `dump_valid`=1 next cycle, `core_run`=0.
- Timeout and priority:
  - Stimulus A: budget 5, no halt.
  - Response A: `cycle_cnt`=5, `timeout`=1.
  - Stimulus B: budget 5 with halt on cycle 5.
  - Response B: `timeout`=0.
  - Stimulus C: budget 0.
  - Response C: no timeout after 1000 cycles.
- Dump backpressure:
  - Stimulus: `rf_rdata`=idx·0x1111; `dump_ready` random.
  - Response: 32 beats, indices 0..31 in order, each exactly once with matching data and stable while stalled; `done`=1 after beat 31; `restart` returns to LOAD.
- Reset mid-run:
  - Stimulus: `rst` on RUN cycle 3.
  - Response: next cycle LOAD, `core_rst`=1, `cycle_cnt`=0, no dump beats.
